dcache_responder: RTL

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/dcache_responder_if.sv | 34 +++
 rtl/dcache_responder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dcache_responder_if.sv
// dcache_responder_if -- bundles the pipeline-side and memory-side buses of
// the data cache responder.
//   pipeline side : dmemREN, dmemWEN, dmemaddr, dmemstore, halt  (to cache)
//                   dhit, dmemload, flushed                       (from cache)
//   memory side   : dREN, dWEN, daddr, dstore                     (from cache)
//                   dwait, dload                                  (to cache)
// modport slave is the cache's view; modport master is the view of whatever
// drives the pipeline requests and models memory.
interface dcache_responder_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder -- direct-mapped, write-back, write-allocate data cache
// with one 32-bit word per frame and a halt-triggered writeback flush.
//   CLK   : system clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : dcache_responder_if.slave (pipeline request/response + memory port)
// A hit completes combinationally in IDLE. A miss goes IDLE->(WB)->ALLOC->IDLE
// and then hits on the following cycle. On halt every dirty frame is written
// back in index order, after which the block parks in HALTED with flushed=1.
module dcache_responder #(
    parameter int SETS = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    dcache_responder_if.slave     bus
);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB     = 3'd1;
    localparam logic [2:0] S_ALLOC  = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]      state;
    logic [IDXW-1:0] fcnt;
    logic [SETS-1:0] valid;
    logic [SETS-1:0] dirty;
    logic [TAGW-1:0] tags [SETS];
    logic [31:0]     data [SETS];

    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic            req, hit, wr_hit, fdirty;
    logic            unused_addr_lsb;

    assign idx             = bus.dmemaddr[IDXW+1:2];
    assign tag             = bus.dmemaddr[31:IDXW+2];
    assign unused_addr_lsb = ^bus.dmemaddr[1:0];
    assign req             = bus.dmemREN | bus.dmemWEN;
    assign hit             = valid[idx] && (tags[idx] == tag);
    // REN+WEN together is a write, so only WEN decides the direction.
    assign wr_hit          = (state == S_IDLE) && bus.dmemWEN && hit;
    assign fdirty          = valid[fcnt] && dirty[fcnt];

    always_comb begin
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        bus.flushed  = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        case (state)
            S_IDLE: begin
                if (req && hit) begin
                    bus.dhit = 1'b1;
                    if (!bus.dmemWEN) bus.dmemload = data[idx];
                end
            end
            S_WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {tags[idx], idx, 2'b00};
                bus.dstore = data[idx];
            end
            S_ALLOC: begin
                bus.dREN  = 1'b1;
                bus.daddr = {bus.dmemaddr[31:2], 2'b00};
            end
            S_FLUSH: begin
                if (fdirty) begin
                    bus.dWEN   = 1'b1;
                    bus.daddr  = {tags[fcnt], fcnt, 2'b00};
                    bus.dstore = data[fcnt];
                end
            end
            S_HALTED: bus.flushed = 1'b1;
            default: ;
        endcase
    end

    // Control state: valid/dirty live here so reset clears them at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
            fcnt  <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (bus.dmemWEN) dirty[idx] <= 1'b1;
                        end else if (valid[idx] && dirty[idx]) begin
                            state <= S_WB;
                        end else begin
                            state <= S_ALLOC;
                        end
                    end else if (bus.halt) begin
                        state <= S_FLUSH;
                        fcnt  <= '0;
                    end
                end
                // Dirty is left set here; ALLOC overwrites the frame and clears it.
                S_WB: if (!bus.dwait) state <= S_ALLOC;
                S_ALLOC: begin
                    if (!bus.dwait) begin
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (!fdirty || !bus.dwait) begin
                        if (fdirty) dirty[fcnt] <= 1'b0;
                        if (fcnt == '1) state <= S_HALTED;
                        else            fcnt  <= fcnt + 1'b1;
                    end
                end
                S_HALTED: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Frame payload has no reset. Reset forces IDLE with all frames invalid,
    // so neither update below can fire while nRST is low.
    always_ff @(posedge CLK) begin
        if (state == S_ALLOC && !bus.dwait) begin
            data[idx] <= bus.dload;
            tags[idx] <= tag;
        end else if (wr_hit) begin
            data[idx] <= bus.dmemstore;
        end
    end
endmodule
